// File: rtl/fifo_nibble_tx_if.sv
// fifo_nibble_tx_if: groups the FIFO read side (empty/q/pop) with the serial
// line and status outputs of the nibble transmitter.
// master: the transmitter. slave: the FIFO and line environment around it.
interface fifo_nibble_tx_if #(
  parameter int WIDTH = 4
) ();

  logic             empty;
  logic [WIDTH-1:0] q;
  logic             pop;
  logic             tx;
  logic             busy;
  logic             frame_done;

  modport master (
    input  empty,
    input  q,
    output pop,
    output tx,
    output busy,
    output frame_done
  );

  modport slave (
    output empty,
    output q,
    input  pop,
    input  tx,
    input  busy,
    input  frame_done
  );

endinterface

// File: rtl/fifo_nibble_tx.sv
// fifo_nibble_tx: drains a FIFO one word at a time and sends each word as an
// asynchronous serial frame: start bit, data LSB first, optional even parity,
// stop bit. Every output is registered.
// Optional feature: define FIFO_NIBBLE_TX_PARITY_EN to add the even-parity bit.
module fifo_nibble_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  fifo_nibble_tx_if.master    bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_FETCH,
    S_START,
    S_DATA,
`ifdef FIFO_NIBBLE_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
`ifdef FIFO_NIBBLE_TX_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             tx_q, tx_d;
  logic             pop_q, pop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  // Next state, datapath update and the registered-output values for the next cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
`ifdef FIFO_NIBBLE_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE:  if (!bus.empty) state_d = S_POP;
      S_POP:   state_d = S_FETCH;
      S_FETCH: begin
        // q is valid this cycle, one cycle after the pop strobe.
        shreg_d = bus.q;
        idx_d   = '0;
`ifdef FIFO_NIBBLE_TX_PARITY_EN
        par_d   = 1'b0;
`endif
        state_d = S_START;
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
`ifdef FIFO_NIBBLE_TX_PARITY_EN
          par_d = par_q ^ shreg_q[0];
`endif
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_MAX) begin
`ifdef FIFO_NIBBLE_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef FIFO_NIBBLE_TX_PARITY_EN
      S_PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the upcoming state so they can be registered.
    pop_d  = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX);
    tx_d   = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef FIFO_NIBBLE_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
`ifdef FIFO_NIBBLE_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
`ifdef FIFO_NIBBLE_TX_PARITY_EN
      par_q   <= par_d;
`endif
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.pop        = pop_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// tb_fifo_nibble_tx: directed bench for fifo_nibble_tx with a queue standing in
// for the FIFO. Frame patterns are hand-derived, one bit per tx cycle, LSB = first
// cycle of the start bit.
module tb_fifo_nibble_tx;

  localparam int CPB = 4;
`ifdef FIFO_NIBBLE_TX_PARITY_EN
  localparam int FRAME_CYC = 28;
  localparam logic [27:0] EXP_A = 28'hF0F0F00;
  localparam logic [27:0] EXP_7 = 28'hFF0FFF0;
  localparam logic [27:0] EXP_1 = 28'hFF000F0;
  localparam logic [27:0] EXP_2 = 28'hFF00F00;
  localparam logic [27:0] EXP_3 = 28'hF000FF0;
  localparam logic [27:0] EXP_5 = 28'hF00F0F0;
`else
  localparam int FRAME_CYC = 24;
  localparam logic [27:0] EXP_A = 28'h0FF0F00;
  localparam logic [27:0] EXP_7 = 28'h0F0FFF0;
  localparam logic [27:0] EXP_1 = 28'h0F000F0;
  localparam logic [27:0] EXP_2 = 28'h0F00F00;
  localparam logic [27:0] EXP_3 = 28'h0F00FF0;
  localparam logic [27:0] EXP_5 = 28'h0F0F0F0;
`endif
  localparam int PERIOD = FRAME_CYC + 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_nibble_tx_if #(.WIDTH(4)) bus ();

  fifo_nibble_tx #(.WIDTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc;
  int pop_cnt;
  int done_cnt;
  int last_done;
  int pop_cyc [4];
  int zeros;
  logic tx_log   [0:255];
  logic busy_log [0:255];
  logic [3:0] fifo_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, log outputs, then play the FIFO.
  task automatic run_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 256) begin
      tx_log[cyc]   = bus.tx;
      busy_log[cyc] = bus.busy;
    end
    if (bus.pop) begin
      if (pop_cnt < 4) pop_cyc[pop_cnt] = cyc;
      pop_cnt++;
      if (fifo_q.size() > 0) bus.q = fifo_q.pop_front();
    end
    if (bus.frame_done) begin
      done_cnt++;
      last_done = cyc;
    end
    bus.empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic new_window();
    cyc       = 0;
    pop_cnt   = 0;
    done_cnt  = 0;
    last_done = -1;
    for (int i = 0; i < 4; i++) pop_cyc[i] = -1;
  endtask

  task automatic check_frame(input string tag, input int start, input logic [27:0] exp);
    logic [27:0] obs;
    obs = '0;
    for (int i = 0; i < FRAME_CYC; i++) obs[i] = tx_log[start + i];
    check(tag, {4'b0, obs}, {4'b0, exp});
  endtask

  initial begin
    reset     = 1'b0;
    bus.q     = 4'h0;
    fifo_q.push_back(4'hA);
    bus.empty = 1'b0;
    new_window();

    // Reset held with a non-empty FIFO: idle outputs, no pop.
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("rst_tx",   32'(bus.tx), 1);
      check("rst_pop",  32'(bus.pop), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.frame_done), 0);
    end
    check("rst_no_pop", pop_cnt, 0);

    // Single frame, q=A; the first edge after release is edge 0.
    reset = 1'b1;
    new_window();
    run(FRAME_CYC + 6);
    check("a_pop_cnt", pop_cnt, 1);
    check("a_pop_cyc", pop_cyc[0], 1);
    check("a_busy_pop", 32'(busy_log[1]), 1);
    check("a_tx_fetch", 32'(tx_log[2]), 1);
    check_frame("a_frame", 3, EXP_A);
    check("a_done_cnt", done_cnt, 1);
    check("a_done_cyc", last_done, FRAME_CYC + 2);
    check("a_busy_last", 32'(busy_log[FRAME_CYC + 2]), 1);
    check("a_busy_fall", 32'(busy_log[FRAME_CYC + 3]), 0);
    check("a_tx_idle", 32'(tx_log[FRAME_CYC + 3]), 1);

    // Single frame, q=7 (parity 1 when enabled).
    fifo_q.push_back(4'h7);
    bus.empty = 1'b0;
    new_window();
    run(FRAME_CYC + 6);
    check("s7_pop_cnt", pop_cnt, 1);
    check_frame("s7_frame", 3, EXP_7);
    check("s7_done_cyc", last_done, FRAME_CYC + 2);

    // Back-to-back: three queued words drain with fixed spacing.
    fifo_q.push_back(4'h1);
    fifo_q.push_back(4'h2);
    fifo_q.push_back(4'h3);
    bus.empty = 1'b0;
    new_window();
    run(3 * PERIOD + 10);
    check("b2b_pop_cnt", pop_cnt, 3);
    check("b2b_pop0", pop_cyc[0], 1);
    check("b2b_pop1", pop_cyc[1], 1 + PERIOD);
    check("b2b_pop2", pop_cyc[2], 1 + 2 * PERIOD);
    check_frame("b2b_frame1", 3, EXP_1);
    check_frame("b2b_frame2", 3 + PERIOD, EXP_2);
    check_frame("b2b_frame3", 3 + 2 * PERIOD, EXP_3);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_gap_tx", 32'(tx_log[FRAME_CYC + 5]), 1);
    run(20);
    check("b2b_no_extra_pop", pop_cnt, 3);

    // Empty held high: the line stays idle.
    new_window();
    run(100);
    zeros = 0;
    for (int i = 1; i <= 100; i++) if (tx_log[i] !== 1'b1) zeros++;
    check("empty_pop_cnt", pop_cnt, 0);
    check("empty_tx_low", zeros, 0);
    check("empty_done", done_cnt, 0);

    // Reset during the second data bit of q=E (bits 0,1,1,1).
    fifo_q.push_back(4'hE);
    bus.empty = 1'b0;
    new_window();
    run(11);
    check("mid_tx_bit0", 32'(tx_log[10]), 0);
    check("mid_tx_bit1", 32'(tx_log[11]), 1);
    check("mid_busy", 32'(busy_log[11]), 1);
    reset = 1'b0;
    run_cycle();
    check("mid_rst_tx", 32'(bus.tx), 1);
    check("mid_rst_busy", 32'(bus.busy), 0);
    run(2);
    check("mid_rst_done", done_cnt, 0);
    check("mid_rst_tx_hold", 32'(bus.tx), 1);
    reset = 1'b1;

    // After release, the next word goes out normally.
    fifo_q.push_back(4'h5);
    bus.empty = 1'b0;
    new_window();
    run(FRAME_CYC + 6);
    check("post_pop_cnt", pop_cnt, 1);
    check("post_pop_cyc", pop_cyc[0], 1);
    check_frame("post_frame", 3, EXP_5);
    check("post_done_cyc", last_done, FRAME_CYC + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_nibble_tx.md
# fifo_nibble_tx

Downstream drain stage for the 4-bit `fifo`. Pops one word at a time whenever the FIFO reports non-empty, then transmits it as an asynchronous serial frame on a single line: start bit, data LSB-first, optional even-parity bit, stop bit. This gives the FIFO a real consumer, so push-side bursts are paced out at a fixed bit rate.

## Interface
- `WIDTH`, 4: data word width; matches the FIFO `q` width.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit, ≥1. The bit counter is $clog2(CLKS_PER_BIT) wide, minimum 1 bit.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `empty`  in  1  FIFO empty flag.
- `q`  in  WIDTH  FIFO read data; valid on the cycle after `pop` is high.
- `pop`  out  1  FIFO read strobe; registered, high for exactly one cycle per word.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from the POP state through the end of STOP.
- `frame_done`  out  1  one-cycle pulse in the last cycle of STOP.

## Operation
- FSM states, all outputs registered: IDLE, POP, FETCH, START, DATA, PARITY (macro only), STOP.
- **IDLE:** `tx`=1 and `busy`=0. If `empty`=0 is sampled, go to POP. Otherwise stay in IDLE.
- **POP:** `pop`=1 for this one cycle, then go to FETCH.
- **FETCH:** at the end of the cycle, capture `q` into the shift register and clear the parity accumulator. Go to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles.
- **DATA:** WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary. The bit index counts 0..WIDTH-1.
- **PARITY:** one bit period carrying the XOR of all data bits (even parity).
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles. `frame_done`=1 in the final cycle. Then go to IDLE.
- `empty` is ignored in every state except IDLE.
- Only one `pop` is issued per frame, so the block never over-reads the FIFO.
- **Reset:** `tx`=1, `pop`=0, `busy`=0, `frame_done`=0, state IDLE, counters and shift register cleared.
- **Reset mid-frame:** the line returns high on the next edge and the in-flight word is dropped, not retried.

## Timing
- The bit counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary. The state advances on the wrap.
- Edge 0 samples `empty`=0 in IDLE.
- `pop` is high during cycle 1.
- `q` is captured at the end of cycle 2.
- `tx` falls at the start of cycle 3.
- Frame length is (WIDTH+2) × CLKS_PER_BIT cycles without parity and (WIDTH+3) × CLKS_PER_BIT with parity. With defaults this is 24 or 28 cycles.
- **Back-to-back frames:** STOP end → IDLE (1 cycle) → POP → FETCH. This gives 3 extra idle-high cycles between consecutive stop and start bits.
- `busy` rises together with `pop` and falls on the cycle after `frame_done`.
- If CLKS_PER_BIT=1, every bit lasts one cycle and there is no degenerate state skipping.

## Configuration
- `FIFO_NIBBLE_TX_PARITY_EN` defined: the PARITY state is compiled in, and an even-parity bit is sent between the last data bit and STOP.
- Macro undefined: the PARITY state and the accumulator are absent, and DATA goes directly to STOP.

## Test plan
- **Reset values:** `reset`=0 for 3 cycles with `empty`=0 → `tx`=1, `pop`=0, `busy`=0, `frame_done`=0 throughout. There is no pop during reset.
- **Single frame, parity off, CLKS_PER_BIT=4:** `q`=4'hA, `empty` low for one IDLE sample.
  - `pop` is high for 1 cycle.
  - `tx` = 0 (start), 0, 1, 0, 1 (data), 1 (stop), each held 4 cycles.
  - `frame_done` pulses at cycle 26 counted from the IDLE sample.
- **Parity on:** `q`=4'h7 → data bits 1,1,1,0, then parity bit 1, then stop. With `q`=4'hA the parity bit is 0.
- **Back-to-back:** FIFO preloaded with 1, 2, 3, `empty` low until drained.
  - Exactly 3 `pop` pulses, spaced 27 cycles apart (parity off).
  - 3 frames with data 1, 2, 3 in order.
  - No pop after `empty` goes high.
- **Empty held high:** 100 cycles → no `pop`, `tx`=1 constant.
- **Reset mid-DATA:** assert `reset`=0 on the 2nd data bit.
  - `tx`=1 on the next edge, `busy`=0, no `frame_done`.
  - After release, the next non-empty word is sent normally.
